// File: rtl/genius_round_sequencer_pkg.sv
// Shared types and helpers for the Genius (Simon) round sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package genius_round_sequencer_pkg;

    // Colour codes carried on in_color and stored in the sequence array.
    typedef enum logic [1:0] {
        C_GREEN  = 2'd0,
        C_RED    = 2'd1,
        C_YELLOW = 2'd2,
        C_BLUE   = 2'd3
    } colour_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/genius_round_sequencer_lfsr.sv
// 16-bit Fibonacci LFSR supplying two random bits per cycle for new sequence colours.
// Latency: bits_o reflects the register; it advances one step per enabled cycle.
// Backpressure: none; free-running while en_i is high.
// Ports: clk clock; rst async active-low reset (loads SEED); en_i shift enable;
//        bits_o low two bits of the shift register.
module genius_round_sequencer_lfsr
    import genius_round_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [1:0] bits_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bits_o = lfsr_q[1:0];

endmodule

// File: rtl/genius_round_sequencer.sv
// Runs one Genius game: grows a random colour sequence, plays it on the lamps, judges presses.
// Latency: all outputs registered; a press is judged on the edge that samples in_rdy.
// Backpressure: none; in_rdy strobes outside WAIT_IN and start while busy are dropped.
// Ports: clk clock; rst async active-low reset; start new-game pulse; in_rdy/in_color player
//        press strobe and colour; led one-hot lamp; level current sequence length;
//        busy game in progress; win/lose held game result until the next start.
module genius_round_sequencer
    import genius_round_sequencer_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned SHOW_CYC    = 25000000,
    parameter int unsigned GAP_CYC     = 12500000,
    parameter int unsigned TIMEOUT_CYC = 250000000,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_rdy,
    input  logic [1:0]                       in_color,
    output logic [3:0]                       led,
    output logic [$clog2(MAX_LEN+1)-1:0]     level,
    output logic                             busy,
    output logic                             win,
    output logic                             lose
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned TW = $clog2(max3(SHOW_CYC, GAP_CYC, TIMEOUT_CYC));

    localparam logic [TW-1:0] T_SHOW    = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] T_GAP     = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE       = LW'(1);

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      led_q, led_d;
    logic            busy_q, busy_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;

    logic [1:0]      seq_q [MAX_LEN];
    logic            seq_we;
    logic [1:0]      rnd;

    logic [LW-1:0]   last_idx;
    logic [LW-1:0]   idx_nxt;
    logic [TW-1:0]   timer_dec;
    logic            timer_zero;

    genius_round_sequencer_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .bits_o (rnd)
    );

    assign last_idx   = len_q - ONE;
    assign idx_nxt    = idx_q + ONE;
    assign timer_zero = (timer_q == '0);
    // Saturating count-down: the counter never wraps past zero.
    assign timer_dec  = timer_zero ? timer_q : timer_q - TW'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        led_d   = led_q;
        win_d   = win_q;
        lose_d  = lose_q;
        seq_we  = 1'b0;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_d = S_ADD;
                    len_d   = '0;
                    idx_d   = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    led_d   = 4'b0000;
                end
            end

            S_ADD: begin
                seq_we  = 1'b1;
                len_d   = len_q + ONE;
                idx_d   = '0;
                timer_d = T_SHOW;
                state_d = S_SHOW_ON;
                // Playback starts at seq[0]; on the first round that entry is the one
                // being written on this very edge, so bypass the array.
                led_d   = onehot((len_q == '0) ? rnd : seq_q[0]);
            end

            S_SHOW_ON: begin
                if (timer_zero) begin
                    state_d = S_SHOW_OFF;
                    timer_d = T_GAP;
                    led_d   = 4'b0000;
                end else begin
                    timer_d = timer_dec;
                end
            end

            S_SHOW_OFF: begin
                led_d = 4'b0000;
                if (timer_zero) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        timer_d = T_TIMEOUT;
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = idx_nxt;
                        timer_d = T_SHOW;
                        led_d   = onehot(seq_q[idx_nxt[IW-1:0]]);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_dec;
                end
            end

            S_WAIT_IN: begin
                led_d = 4'b0000;
                // A press landing on the expiry cycle still counts.
                if (in_rdy) begin
                    if (in_color == seq_q[idx_q[IW-1:0]]) begin
                        if (idx_q == last_idx) begin
                            if (len_q == LEN_MAX) begin
                                state_d = S_WIN;
                                win_d   = 1'b1;
                            end else begin
                                state_d = S_ADD;
                            end
                        end else begin
                            idx_d   = idx_nxt;
                            timer_d = T_TIMEOUT;
                        end
                    end else begin
                        state_d = S_LOSE;
                        lose_d  = 1'b1;
                    end
                end else if (timer_zero) begin
                    state_d = S_LOSE;
                    lose_d  = 1'b1;
                end else begin
                    timer_d = timer_dec;
                end
            end

            default: begin
                state_d = S_IDLE;
                led_d   = 4'b0000;
            end
        endcase

        busy_d = !(state_d inside {S_IDLE, S_WIN, S_LOSE});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            led_q   <= 4'b0000;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Sequence storage is deliberately not reset: each round overwrites its slot
    // before it is ever played or judged.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[len_q[IW-1:0]] <= rnd;
        end
    end

    assign led   = led_q;
    assign level = len_q;
    assign busy  = busy_q;
    assign win   = win_q;
    assign lose  = lose_q;

endmodule

// File: tb/tb_genius_round_sequencer.sv
module tb_genius_round_sequencer;

    localparam int MAX_LEN     = 3;
    localparam int SHOW_CYC    = 4;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 20;
    localparam int LW          = $clog2(MAX_LEN + 1);

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          in_rdy   = 1'b0;
    logic [1:0]    in_color = 2'd0;
    logic [3:0]    led;
    logic [LW-1:0] level;
    logic          busy;
    logic          win;
    logic          lose;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [MAX_LEN];

    genius_round_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYC    (SHOW_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_rdy   (in_rdy),
        .in_color (in_color),
        .led      (led),
        .level    (level),
        .busy     (busy),
        .win      (win),
        .lose     (lose)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, left-shifting, free-running.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] v;
        v = 4'b0001;
        return v << c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        in_rdy   = 1'b1;
        in_color = c;
        tick();
        in_rdy   = 1'b0;
    endtask

    // Entered in the ADD cycle of round L; leaves at the first WAIT_IN cycle.
    task automatic play_round(input int L, input bit noise);
        exp_seq[L-1] = m_lfsr[1:0];
        chk("add_busy",  32'(busy),  32'd1);
        chk("add_level", 32'(level), 32'(L - 1));
        chk("add_led",   32'(led),   32'd0);
        chk("add_win",   32'(win),   32'd0);
        chk("add_lose",  32'(lose),  32'd0);
        tick();
        for (int i = 0; i < L; i++) begin
            for (int c = 0; c < SHOW_CYC; c++) begin
                chk("show_on_led", 32'(led), 32'(oh(exp_seq[i])));
                if (c == 0) chk("show_level", 32'(level), 32'(L));
                if (noise) begin
                    in_rdy   = 1'b1;
                    in_color = 2'($urandom_range(0, 3));
                end
                tick();
                in_rdy = 1'b0;
            end
            for (int c = 0; c < GAP_CYC; c++) begin
                chk("show_off_led",  32'(led),  32'd0);
                chk("show_off_busy", 32'(busy), 32'd1);
                if (noise) begin
                    in_rdy   = 1'b1;
                    in_color = 2'($urandom_range(0, 3));
                end
                tick();
                in_rdy = 1'b0;
            end
        end
        chk("wait_led",   32'(led),   32'd0);
        chk("wait_busy",  32'(busy),  32'd1);
        chk("wait_level", 32'(level), 32'(L));
    endtask

    task automatic answer_all(input int L);
        for (int i = 0; i < L; i++) begin
            press(exp_seq[i]);
            if (i < L - 1) begin
                chk("mid_busy", 32'(busy), 32'd1);
                chk("mid_lose", 32'(lose), 32'd0);
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led",   32'(led),   32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_win",   32'(win),   32'd0);
        chk("rst_lose",  32'(lose),  32'd0);
        rst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of SHOW_ON
        do_start();
        exp_seq[0] = m_lfsr[1:0];
        tick();
        chk("pre_rst_led", 32'(led), 32'(oh(exp_seq[0])));
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_led",   32'(led),   32'd0);
        chk("async_busy",  32'(busy),  32'd0);
        chk("async_level", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("post_rst_busy",  32'(busy),  32'd0);
        chk("post_rst_led",   32'(led),   32'd0);
        chk("post_rst_level", 32'(level), 32'd0);

        // Full winning game with ignored presses during playback and start during WAIT_IN
        do_start();
        play_round(1, 1'b0);
        answer_all(1);
        play_round(2, 1'b1);
        answer_all(2);
        play_round(3, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ign_busy",  32'(busy),  32'd1);
        chk("start_ign_level", 32'(level), 32'd3);
        chk("start_ign_led",   32'(led),   32'd0);
        answer_all(3);
        chk("win_win",   32'(win),   32'd1);
        chk("win_lose",  32'(lose),  32'd0);
        chk("win_busy",  32'(busy),  32'd0);
        chk("win_level", 32'(level), 32'd3);
        chk("win_led",   32'(led),   32'd0);
        repeat (3) tick();
        chk("win_hold",       32'(win),   32'd1);
        chk("win_hold_level", 32'(level), 32'd3);

        // Second game: start clears win; wrong colour on 2nd press of round 2
        do_start();
        play_round(1, 1'b0);
        answer_all(1);
        play_round(2, 1'b0);
        press(exp_seq[0]);
        chk("r2_first_ok", 32'(lose), 32'd0);
        press(exp_seq[1] ^ 2'b01);
        chk("wrong_lose",  32'(lose),  32'd1);
        chk("wrong_level", 32'(level), 32'd2);
        chk("wrong_led",   32'(led),   32'd0);
        chk("wrong_busy",  32'(busy),  32'd0);
        chk("wrong_win",   32'(win),   32'd0);
        tick();
        chk("lose_hold",       32'(lose),  32'd1);
        chk("lose_hold_level", 32'(level), 32'd2);

        // Timeout with no press
        do_start();
        play_round(1, 1'b0);
        repeat (TIMEOUT_CYC - 1) tick();
        chk("to_edge_lose", 32'(lose), 32'd0);
        chk("to_edge_busy", 32'(busy), 32'd1);
        tick();
        chk("to_lose",  32'(lose),  32'd1);
        chk("to_level", 32'(level), 32'd1);
        chk("to_busy",  32'(busy),  32'd0);

        // Presses landing exactly on the expiry cycle are accepted; timer reloads per press
        do_start();
        play_round(1, 1'b0);
        repeat (TIMEOUT_CYC - 1) tick();
        press(exp_seq[0]);
        chk("late_ok_lose", 32'(lose), 32'd0);
        chk("late_ok_busy", 32'(busy), 32'd1);
        play_round(2, 1'b0);
        repeat (10) tick();
        press(exp_seq[0]);
        repeat (TIMEOUT_CYC - 1) tick();
        chk("reload_lose", 32'(lose), 32'd0);
        press(exp_seq[1]);
        chk("late2_lose", 32'(lose), 32'd0);
        chk("late2_busy", 32'(busy), 32'd1);
        play_round(3, 1'b0);
        repeat (TIMEOUT_CYC) tick();
        chk("to3_lose",  32'(lose),  32'd1);
        chk("to3_level", 32'(level), 32'd3);
        chk("to3_led",   32'(led),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
